// File: rtl/pipe_out_buffer.sv
// Result buffer for an external arithmetic pipeline; optional popped-result accumulator under PIPE_OUT_SUM_EN.
// Holds an LAT+1 token shift register and a credit-checked DEPTH-entry result FIFO.

// pipe_out_fifo: DEPTH-entry result FIFO with extra-bit pointers for full/empty.
// Latency: a write is visible on rd_vld/rd_dat the cycle after the write edge.
// Backpressure: writes while full are refused; rd_dat holds steady until rd_rdy pops it.
module pipe_out_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  occ;
  logic         push;
  logic         pop;

  assign occ    = wr_ptr - rd_ptr;
  assign rd_vld = (occ != '0);
  assign push   = wr_vld && (occ != FULL_OCC);
  assign pop    = rd_vld && rd_rdy;
  // Empty FIFO presents zero rather than a stale entry.
  assign rd_dat = rd_vld ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

// pipe_out_buffer: captures f_in LAT+1 edges after each accepted token and queues it (LAT >= 1).
// Latency: accept edge k -> FIFO write at edge k+LAT+1 -> out_valid the cycle after.
// Backpressure: in_ready from registered credits (occupancy + in flight < DEPTH); refused tokens set overflow.
module pipe_out_buffer #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] f_in,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow,
  output logic [15:0]  count,
  output logic [N+7:0] sum
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CREDIT_ONE = CW'(1);

  logic [LAT:0]  tok_sr;
  logic [CW-1:0] credit_used;
  logic          accept;
  logic          pop;
  logic          res_vld;

  // A credit is held from acceptance until the result is popped, so it covers
  // both in-flight tokens and FIFO entries with a single registered counter.
  assign in_ready = (credit_used < CREDIT_MAX);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign res_vld  = tok_sr[LAT];

  always_ff @(posedge clk) begin
    if (rst) tok_sr <= '0;
    else     tok_sr <= {tok_sr[LAT-1:0], accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   credit_used <= credit_used + CREDIT_ONE;
        2'b01:   credit_used <= credit_used - CREDIT_ONE;
        default: credit_used <= credit_used;
      endcase
    end
  end

  pipe_out_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (res_vld),
    .wr_dat (f_in),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (pop)                   count    <= count + 16'd1;
    end
  end

`ifdef PIPE_OUT_SUM_EN
  always_ff @(posedge clk) begin
    if (rst)      sum <= '0;
    else if (pop) sum <= sum + {8'b0, out_data};
  end
`else
  assign sum = '0;
`endif
endmodule

// File: tb/tb_pipe_out_buffer.sv
// Directed bench for pipe_out_buffer with a behavioural model of the upstream arithmetic pipeline.
module tb_pipe_out_buffer;
  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
`ifdef PIPE_OUT_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] f_in;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;
  logic [15:0]  count;
  logic [N+7:0] sum;

  logic [7:0]   op_a, op_b, op_c, op_d;
  logic [N-1:0] pipe [LAT+1];
  logic [N-1:0] q [$];
  logic [N+7:0] exp_sum;
  int           exp_count;
  int           tok;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  pipe_out_buffer #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_in      (f_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .count     (count),
    .sum       (sum)
  );

  function automatic logic [N-1:0] f_model(input logic [7:0] a, b, c, d);
    logic [31:0] t;
    t = (32'(a) + 32'(c)) * 32'(d) + 32'(b);
    return t[N-1:0];
  endfunction

  // Upstream pipeline: operands captured every edge, result register LAT edges later, no reset.
  always @(posedge clk) begin
    pipe[0] <= f_model(op_a, op_b, op_c, op_d);
    for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign f_in = pipe[LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_ops();
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    op_c = 8'($urandom);
    op_d = 8'($urandom);
  endtask

  task automatic set_ops(input int a, input int b, input int c, input int d);
    op_a = 8'(a);
    op_b = 8'(b);
    op_c = 8'(c);
    op_d = 8'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    idle_ops();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_overflow",  overflow,  0);
    chk("rst_count",     count,     0);
    chk("rst_sum",       sum,       0);
    rst = 1'b0;
    exp_count = 0;
    exp_sum   = '0;
    q.delete();
    @(negedge clk);
  endtask

  // Well-behaved source (offers only when in_ready) against an optionally toggling sink.
  task automatic stream(input int cycles, input bit toggle);
    logic [N-1:0] held;
    bit           stalled;
    held = '0;
    stalled = 1'b0;
    for (int cyc = 0; cyc < cycles + 24; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_vld", out_valid, 1);
        chk("stall_dat", out_data, held);
      end
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_result", out_valid, 0);
        end else begin
          chk("order", out_data, q[0]);
          exp_sum = exp_sum + (N+8)'(q[0]);
          exp_count++;
          void'(q.pop_front());
        end
      end
      if (cyc < cycles && in_ready) begin
        tok++;
        set_ops(tok % 256, 3, tok % 5, 2);
        in_valid = 1'b1;
        q.push_back(f_model(op_a, op_b, op_c, op_d));
      end else begin
        in_valid = 1'b0;
        idle_ops();
      end
      chk("credits", (q.size() <= DEPTH), 1);
      stalled = out_valid && !out_ready;
      held = out_data;
    end
    in_valid = 1'b0;
    chk("drained",      q.size(), 0);
    chk("stream_count", count, exp_count);
    chk("stream_sum",   sum, SUM_ON ? exp_sum : 0);
    chk("stream_ovf",   overflow, 0);
    q.delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tok = 0;
    exp_count = 0; exp_sum = '0;
    idle_ops();

    // Single token latency and value.
    do_reset();
    out_ready = 1'b1;
    set_ops(3, 4, 5, 2);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    idle_ops();
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", lat, LAT + 2);
    chk("first_data", out_data, 20);
    exp_count++;
    exp_sum = exp_sum + (N+8)'(20);
    @(negedge clk);
    chk("first_count", count, exp_count);
    chk("first_sum", sum, SUM_ON ? exp_sum : 0);
    chk("first_empty", out_valid, 0);

    // Eight offers into a stalled sink: four accepted, then overflow.
    out_ready = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      set_ops(j, 0, 0, 1);
      in_valid = 1'b1;
      chk("fill_in_ready", in_ready, (j <= DEPTH) ? 1 : 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle_ops();
    chk("fill_overflow", overflow, 1);
    repeat (LAT + 2) @(negedge clk);
    chk("fill_vld", out_valid, 1);
    chk("fill_head", out_data, 1);
    @(negedge clk);
    chk("fill_hold", out_data, 1);
    for (int j = 1; j <= DEPTH; j++) begin
      out_ready = 1'b1;
      chk("drain_vld", out_valid, 1);
      chk("drain_dat", out_data, j);
      exp_count++;
      exp_sum = exp_sum + (N+8)'(j);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_count", count, exp_count);
    chk("drain_sum", sum, SUM_ON ? exp_sum : 0);
    chk("drain_ovf_sticky", overflow, 1);
    chk("drain_in_ready", in_ready, 1);

    // Continuous stream, then a stream with a toggling sink.
    do_reset();
    stream(30, 1'b0);
    stream(20, 1'b1);

    // Reset with tokens in flight: nothing may surface afterwards.
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_ops(j + 7, 1, 1, 1);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle_ops();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    exp_sum = '0;
    for (int c = 0; c < 12; c++) begin
      chk("flush_no_result", out_valid, 0);
      @(negedge clk);
    end
    chk("flush_count", count, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_sum", sum, 0);

    // Ten single tokens exercising pointer wrap.
    for (int i = 1; i <= 10; i++) begin
      set_ops(i, 0, 0, 1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      idle_ops();
      w = 1;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("wrap_vld", out_valid, 1);
      chk("wrap_dat", out_data, i);
      exp_count++;
      exp_sum = exp_sum + (N+8)'(i);
      @(negedge clk);
    end
    chk("wrap_count", count, 10);
    chk("wrap_sum", sum, SUM_ON ? 55 : 0);
    chk("wrap_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_out_buffer.md
PIPE_OUT_BUFFER -- requirements
Module: pipe_out_buffer

Interface
REQ-001 Parameter N, default 10: data width of the arithmetic-pipeline result f_in and of out_data.
REQ-002 Parameter LAT, default 3: register depth of the upstream arithmetic pipeline (operand capture edge to result register edge).
REQ-003 Parameter DEPTH, default 4 (power of two, >=2): result FIFO entries.
REQ-004 clk  input  1: single clock, all state updates on rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 in_valid  input  1: upstream presents operands A..D to the arithmetic pipeline this cycle.
REQ-007 in_ready  output  1: block guarantees buffer space for a token issued this cycle.
REQ-008 f_in  input  N: result output F of the arithmetic pipeline.
REQ-009 out_data  output  N: FIFO head result.
REQ-010 out_valid  output  1: out_data holds a valid result.
REQ-011 out_ready  input  1: downstream consumer accepts out_data.
REQ-012 overflow  output  1: sticky flag, a token was offered while in_ready was low.
REQ-013 count  output  16: number of results popped since reset.
REQ-014 sum  output  N+8: running sum of popped results (see Configuration).

Function
REQ-015 Token accepted at edge k when in_valid=1 and in_ready=1 at that edge; acceptance sets bit 0 of an LAT+1 bit valid shift register, which shifts one position per edge.
REQ-016 f_in shall be written into the FIFO at edge k+LAT+1 (when shift-register bit LAT is set), matching the cycle the upstream result register holds that token's F.
REQ-017 in_ready = (fifo_occupancy + in-flight token count) < DEPTH, computed from registered state only; no combinational path from out_ready or in_valid.
REQ-018 in_valid=1 with in_ready=0: token not tracked, no write ever occurs for it, overflow set to 1 and held until reset.
REQ-019 Credit scheme guarantees no FIFO write while full; FIFO shall never drop or overwrite an entry.
REQ-020 out_valid=1 iff occupancy>0; out_data = head entry; pop at edge where out_valid=1 and out_ready=1.
REQ-021 First result visible on out_valid in the cycle after its write edge (acceptance-to-out_valid latency LAT+2 cycles).
REQ-022 Simultaneous write and pop: occupancy unchanged, both pointers advance; pop on empty is ignored.
REQ-023 Read/write pointers wrap modulo DEPTH; results leave in acceptance order.
REQ-024 count increments by 1 per pop, wraps 0xFFFF->0x0000.
REQ-025 out_data and out_valid stable while out_valid=1 and out_ready=0.

Reset
REQ-026 rst=1 at an edge: valid shift register cleared, FIFO emptied, pointers 0, out_valid=0, in_ready=1 (next cycle), overflow=0, count=0, sum=0, out_data=0.
REQ-027 Reset mid-operation: tokens in flight are discarded; their F values arriving later shall not be written.
REQ-028 Upstream arithmetic pipeline has no reset; block shall not depend on f_in contents except at REQ-016 write edges.

Configuration
REQ-029 Macro PIPE_OUT_SUM_EN defined: sum accumulates each popped out_data (zero-extended) at the pop edge, wrapping modulo 2^(N+8).
REQ-030 Macro PIPE_OUT_SUM_EN undefined: no accumulator hardware, sum tied to 0; all other behaviour identical.

Verification
REQ-031 After reset, one token A=3,B=4,C=5,D=2 at edge k, out_ready=1 -> out_valid high in cycle after edge k+LAT+1, out_data=20, count=1, sum=20 (macro on) / 0 (macro off).
REQ-032 in_valid held 1 for 8 cycles, out_ready=0 -> exactly 4 accepted, in_ready low after 4th, overflow=1, later draining yields 4 results in issue order.
REQ-033 Continuous in_valid=1 and out_ready=1 -> one result per cycle after fill, occupancy never exceeds DEPTH, overflow stays 0.
REQ-034 out_ready toggled 1,0,1,0 during stream -> out_data stable during stalls, no loss or duplication, count equals tokens issued.
REQ-035 rst pulsed 2 cycles after issuing 3 tokens -> no result ever appears, count=0, in_ready=1 after reset.
REQ-036 Pointer wrap: 10 single tokens with D=1, A=i, B=0, C=0 (i=1..10) -> out_data sequence 1..10, sum=55 (macro on).
